data_mem_arbiter: RTL and testbench

//  Shares the single data_memory port between the core load/store path and a

---
 rtl/data_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares the single data_memory port between the core load/store path and a
// debug/loader requester (program load, memory inspect). A two-state owner
// FSM decides who drives the port each cycle. The core is stalled while it
// does not own the port. Debug burst length and debug starvation are both
// bounded.
//
// Parameters
//   MAX_BURST     max consecutive granted debug accesses while core_req is high
//   STARVE_LIMIT  cycles debug may wait while the core owns the port before a
//                 forced handover
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   core_req/we/width/addr/wdata   core access request (alu_result / rs_2)
//   core_rdata        load data to core, combinational from mem_rdata
//   core_stall        freeze PC / regfile write while the core is not granted
//   dbg_req/we/width/addr/wdata    debug access request
//   dbg_gnt           debug access performed this cycle
//   dbg_rvalid        registered, one cycle after a granted debug read
//   dbg_rdata         registered debug read data (held between reads)
//   mem_write/width/addr/wdata     to data_memory
//   mem_rdata         from data_memory (combinational read)
// ----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_width,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [2:0]  dbg_width,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,

    output logic        mem_write,
    output logic [2:0]  mem_width,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned BurstW  = $clog2(MAX_BURST) + 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT) + 1;

    localparam logic [BurstW-1:0]  BurstLast  = BurstW'(MAX_BURST - 1);
    localparam logic [StarveW-1:0] StarveLast = StarveW'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {
        StCore = 1'b0,
        StDbg  = 1'b1
    } owner_e;

    owner_e             owner_q;
    logic [BurstW-1:0]  burst_cnt_q;
    logic [StarveW-1:0] starve_cnt_q;

    logic core_gnt;

    // ------------------------------------------------------------------------
    // Grants. Qualified with reset so that asserting reset mid-access removes
    // the grant (and with it any write strobe) before the next clock edge.
    // ------------------------------------------------------------------------
    always_comb begin
        core_gnt = reset && core_req && (owner_q == StCore);
        dbg_gnt  = reset && dbg_req  && (owner_q == StDbg);
    end

    assign core_stall = core_req && !core_gnt;
    assign core_rdata = mem_rdata;

    // ------------------------------------------------------------------------
    // Port mux. The owner drives address/data/width even on idle cycles; only
    // the write strobe needs a real grant.
    // ------------------------------------------------------------------------
    always_comb begin
        if (owner_q == StDbg) begin
            mem_width = dbg_width;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else begin
            mem_width = core_width;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end

        if (core_gnt) begin
            mem_write = core_we;
        end else if (dbg_gnt) begin
            mem_write = dbg_we;
        end else begin
            mem_write = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Owner FSM, fairness counters and the debug read-data register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= StCore;
            burst_cnt_q  <= '0;
            starve_cnt_q <= '0;
            dbg_rvalid   <= 1'b0;
            dbg_rdata    <= '0;
        end else begin
            dbg_rvalid <= dbg_gnt && !dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end

            case (owner_q)
                StCore: begin
                    burst_cnt_q <= '0;
                    // starve_cnt_q holds how many earlier consecutive cycles
                    // debug has already waited; this cycle is one more.
                    if (dbg_req && (!core_req || starve_cnt_q >= StarveLast)) begin
                        owner_q      <= StDbg;
                        starve_cnt_q <= '0;
                    end else if (dbg_req) begin
                        if (starve_cnt_q != '1) begin
                            starve_cnt_q <= starve_cnt_q + StarveW'(1);
                        end
                    end else begin
                        starve_cnt_q <= '0;
                    end
                end

                StDbg: begin
                    starve_cnt_q <= '0;
                    // The counter keeps running (saturating) while the core is
                    // idle, so a long unbounded burst hands over on the first
                    // grant after core_req rises; hence >= rather than ==.
                    if (!dbg_req ||
                        (core_req && dbg_gnt && burst_cnt_q >= BurstLast)) begin
                        owner_q     <= StCore;
                        burst_cnt_q <= '0;
                    end else if (dbg_gnt && burst_cnt_q != '1) begin
                        burst_cnt_q <= burst_cnt_q + BurstW'(1);
                    end
                end

                default: begin
                    owner_q <= StCore;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Drives the arbiter with directed scenarios followed by random traffic. A
// small word memory stands in for data_memory. A behavioural model (owner
// flag, wait/burst counts kept as plain integers) predicts every output and
// is compared on each falling edge; a few literal checks pin the model.
// ----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int MB = 4;
    localparam int SL = 8;

    logic        clk;
    logic        reset;
    logic        core_req, core_we;
    logic [2:0]  core_width;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        dbg_req, dbg_we;
    logic [2:0]  dbg_width;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_write;
    logic [2:0]  mem_width;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    data_mem_arbiter #(
        .MAX_BURST    (MB),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_width (core_width),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_width  (dbg_width),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_write  (mem_write),
        .mem_width  (mem_width),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in data_memory: 256 words, combinational read, clocked write.
    logic [31:0] tb_mem [256];
    assign mem_rdata = tb_mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[9:2]] <= mem_wdata;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_dbg_owns = 0;
    int          m_waited   = 0;   // consecutive cycles debug asked while core owned
    int          m_burst    = 0;   // debug grants since debug took the port
    bit          m_rvalid   = 0;
    logic [31:0] m_rdata    = '0;
    bit          n_dbg_owns = 0;
    int          n_waited   = 0;
    int          n_burst    = 0;
    bit          n_rvalid   = 0;
    logic [31:0] n_rdata    = '0;

    always @(posedge clk) begin
        m_dbg_owns = n_dbg_owns;
        m_waited   = n_waited;
        m_burst    = n_burst;
        m_rvalid   = n_rvalid;
        m_rdata    = n_rdata;
    end

    always @(negedge clk) begin
        bit e_cg, e_dg, e_we;
        int w, b;
        e_cg = reset && core_req && !m_dbg_owns;
        e_dg = reset && dbg_req && m_dbg_owns;
        e_we = e_cg ? core_we : (e_dg ? dbg_we : 1'b0);

        chk("core_stall", 32'(core_stall), 32'(core_req && !e_cg));
        chk("dbg_gnt",    32'(dbg_gnt),    32'(e_dg));
        chk("mem_write",  32'(mem_write),  32'(e_we));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(reset ? m_rvalid : 1'b0));
        chk("dbg_rdata",  dbg_rdata,       reset ? m_rdata : 32'h0);
        if (e_cg) begin
            chk("mem_addr_core",  mem_addr,  core_addr);
            chk("mem_width_core", 32'(mem_width), 32'(core_width));
            if (core_we) chk("mem_wdata_core", mem_wdata, core_wdata);
            else         chk("core_rdata", core_rdata, tb_mem[core_addr[9:2]]);
        end
        if (e_dg) begin
            chk("mem_addr_dbg",  mem_addr,  dbg_addr);
            chk("mem_width_dbg", 32'(mem_width), 32'(dbg_width));
            if (dbg_we) chk("mem_wdata_dbg", mem_wdata, dbg_wdata);
        end

        if (!reset) begin
            n_dbg_owns = 0; n_waited = 0; n_burst = 0; n_rvalid = 0; n_rdata = '0;
        end else begin
            n_rvalid = e_dg && !dbg_we;
            n_rdata  = n_rvalid ? tb_mem[dbg_addr[9:2]] : m_rdata;
            if (!m_dbg_owns) begin
                n_burst = 0;
                if (!dbg_req) begin
                    n_dbg_owns = 0; n_waited = 0;
                end else begin
                    w = m_waited + 1;
                    if (!core_req || w >= SL) begin
                        n_dbg_owns = 1; n_waited = 0;
                    end else begin
                        n_dbg_owns = 0; n_waited = w;
                    end
                end
            end else begin
                n_waited = 0;
                if (!dbg_req) begin
                    n_dbg_owns = 0; n_burst = 0;
                end else begin
                    b = m_burst + 1;
                    if (core_req && b >= MB) begin
                        n_dbg_owns = 0; n_burst = 0;
                    end else begin
                        n_dbg_owns = 1; n_burst = b;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n, pulses;
        bit found;
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'(i) * 32'h01010101;
        reset = 0;
        core_req = 1; core_we = 1; core_width = 3'd2; core_addr = 32'h100;
        core_wdata = 32'hDEADBEEF;
        dbg_req = 0; dbg_we = 0; dbg_width = 3'd2; dbg_addr = 32'h0; dbg_wdata = 32'h0;

        // Reset holds everything off; core is stalled by its own request.
        @(negedge clk);
        chk("rst_core_stall", 32'(core_stall), 32'd1);
        chk("rst_mem_write",  32'(mem_write),  32'd0);
        chk("rst_dbg_gnt",    32'(dbg_gnt),    32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);

        // Core store goes straight through.
        cyc(); reset = 1;
        @(negedge clk);
        chk("core_st_write", 32'(mem_write),  32'd1);
        chk("core_st_stall", 32'(core_stall), 32'd0);
        chk("core_st_addr",  mem_addr,        32'h100);
        cyc(); core_we = 0;
        @(negedge clk);
        chk("core_ld_data", core_rdata, 32'hDEADBEEF);

        // Debug read with idle core: handover, grant, then registered data.
        cyc(); core_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h100;
        @(negedge clk);
        chk("dbg_rd_wait", 32'(dbg_gnt), 32'd0);
        cyc();
        @(negedge clk);
        chk("dbg_rd_gnt", 32'(dbg_gnt), 32'd1);
        cyc(); dbg_req = 0;
        @(negedge clk);
        chk("dbg_rd_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("dbg_rd_rdata",  dbg_rdata,       32'hDEADBEEF);
        cyc(); cyc();

        // Starvation bound: request cycle counts as cycle 1, grant lands in SL+1.
        core_req = 1; core_we = 0; core_addr = 32'h20; dbg_req = 1; dbg_addr = 32'h44;
        found = 0; n = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (dbg_gnt) begin n = k; found = 1; break; end
            cyc();
        end
        chk("starve_found", 32'(found), 32'd1);
        chk("starve_cycle", 32'(n), 32'(SL + 1));
        chk("starve_stall", 32'(core_stall), 32'd1);

        // Burst bound: MB grants in total, then core owns the next cycle.
        pulses = 1; found = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            @(negedge clk);
            if (dbg_gnt) pulses++;
            else begin found = 1; break; end
        end
        chk("burst_ended",  32'(found), 32'd1);
        chk("burst_pulses", 32'(pulses), 32'(MB));
        chk("burst_core",   32'(core_stall), 32'd0);

        // Async reset in the middle of a debug write burst.
        cyc(); core_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40;
        dbg_wdata = 32'h12345678;
        cyc();
        @(negedge clk);
        chk("arst_pre_write", 32'(mem_write), 32'd1);
        @(posedge clk); #3; reset = 0;
        #1;
        chk("arst_write_drop", 32'(mem_write), 32'd0);
        chk("arst_gnt_drop",   32'(dbg_gnt),   32'd0);
        cyc(); reset = 1; core_req = 1; core_we = 0;
        @(negedge clk);
        chk("arst_core_owns", 32'(core_stall), 32'd0);
        chk("arst_dbg_off",   32'(dbg_gnt),    32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cyc();
            reset      = ($urandom_range(0, 199) != 0);
            core_req   = ($urandom_range(0, 2) != 0);
            core_we    = $urandom_range(0, 1) == 1;
            core_width = 3'($urandom_range(0, 7));
            core_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            core_wdata = $urandom;
            if ($urandom_range(0, 3) == 0) dbg_req = ~dbg_req;
            dbg_we     = $urandom_range(0, 1) == 1;
            dbg_width  = 3'($urandom_range(0, 7));
            dbg_addr   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            dbg_wdata  = $urandom;
        end
        cyc();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
